mdu_hilo: RTL and testbench

- Iterative multiply/divide unit with HI/LO architectural registers.
- Sits beside the ALU and downstream of the main control/ALU-control decode. Consumes decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests plus rs/rt operands.
- Supplies HI/LO data to the writeback mux.
- Raises a stall to hold the PC/register-file write while an MFHI/MFLO or a new MDU op collides with an operation in flight.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_hilo_if.sv | 17 +
 rtl/mdu_sign_fix.sv | 29 ++
 rtl/mdu_hilo.sv | 130 +++++++++++++
 tb/tb_mdu_hilo.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op/state encodings and default widths for the multiply/divide unit
package mdu_pkg;
   localparam int MDU_XLEN   = 32;
   localparam int MDU_ITER_W = 6;

   typedef enum logic [2:0] {
      MDU_NOP   = 3'b000,
      MDU_MULT  = 3'b001,
      MDU_MULTU = 3'b010,
      MDU_DIV   = 3'b011,
      MDU_DIVU  = 3'b100,
      MDU_MTHI  = 3'b101,
      MDU_MTLO  = 3'b110,
      MDU_RSVD  = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } mdu_state_e;
endpackage

// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - request/response bundle between decode/writeback and the MDU
interface mdu_hilo_if import mdu_pkg::*; #(parameter int XLEN = MDU_XLEN);
   logic [2:0]      op;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;
   logic            mf_rd;
   logic            mf_hi;
   logic [XLEN-1:0] rdata;
   logic            busy;
   logic            done;
   logic            stall;

   modport master (output op, rs_val, rt_val, mf_rd, mf_hi,
                   input  rdata, busy, done, stall);
   modport slave  (input  op, rs_val, rt_val, mf_rd, mf_hi,
                   output rdata, busy, done, stall);
endinterface

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - operand magnitude extraction and result sign restoration
module mdu_sign_fix import mdu_pkg::*; #(parameter int XLEN = MDU_XLEN) (
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic              sgn,
   output logic [XLEN-1:0]   a_mag,
   output logic [XLEN-1:0]   b_mag,
   output logic              a_neg,
   output logic              b_neg,
   input  logic [2*XLEN-1:0] prod_in,
   input  logic              prod_neg,
   output logic [2*XLEN-1:0] prod_out,
   input  logic [XLEN-1:0]   quo_in,
   input  logic              quo_neg,
   output logic [XLEN-1:0]   quo_out,
   input  logic [XLEN-1:0]   rem_in,
   input  logic              rem_neg,
   output logic [XLEN-1:0]   rem_out
);
   assign a_neg = sgn & a[XLEN-1];
   assign b_neg = sgn & b[XLEN-1];
   // Negating the most negative value wraps back to itself, which is the intended magnitude.
   assign a_mag = a_neg ? (~a + 1'b1) : a;
   assign b_mag = b_neg ? (~b + 1'b1) : b;

   assign prod_out = prod_neg ? (~prod_in + 1'b1) : prod_in;
   assign quo_out  = quo_neg  ? (~quo_in  + 1'b1) : quo_in;
   assign rem_out  = rem_neg  ? (~rem_in  + 1'b1) : rem_in;
endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative multiply/divide unit with HI/LO; MDU_EARLY_OUT_EN enables multiply early exit
module mdu_hilo import mdu_pkg::*; #(
   parameter int XLEN   = MDU_XLEN,
   parameter int ITER_W = MDU_ITER_W
) (
   input logic       clk,
   input logic       rst_n,
   mdu_hilo_if.slave bus
);
   mdu_state_e        state;
   logic [ITER_W-1:0] count;
   logic [XLEN-1:0]   hi, lo, mplier;
   logic [2*XLEN-1:0] acc, mcand;
   logic              neg_res, neg_a, div_zero, is_div, done;

   logic              is_signed, a_neg, b_neg, mul_last, busy;
   logic [XLEN-1:0]   a_mag, b_mag, quo_fix, rem_fix;
   logic [2*XLEN-1:0] prod_fix, mul_sum, div_next;
   logic [XLEN:0]     div_sh, div_diff;

   assign is_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);

   mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .a(bus.rs_val), .b(bus.rt_val), .sgn(is_signed),
      .a_mag(a_mag), .b_mag(b_mag), .a_neg(a_neg), .b_neg(b_neg),
      .prod_in(acc), .prod_neg(neg_res), .prod_out(prod_fix),
      .quo_in(acc[XLEN-1:0]), .quo_neg(neg_res), .quo_out(quo_fix),
      .rem_in(acc[2*XLEN-1:XLEN]), .rem_neg(neg_a), .rem_out(rem_fix)
   );

   // Multiply: add the left-shifting multiplicand while the multiplier shifts right.
   assign mul_sum = acc + (mplier[0] ? mcand : '0);

   // Divide: acc holds {remainder, dividend/quotient}; restoring step on the shifted pair.
   assign div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign div_diff = div_sh - {1'b0, mplier};
   assign div_next = {div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0],
                      acc[XLEN-2:0], ~div_diff[XLEN]};

`ifdef MDU_EARLY_OUT_EN
   assign mul_last = (count == '0) || (mplier[XLEN-1:1] == '0);
`else
   assign mul_last = (count == '0);
`endif

   assign busy      = (state != ST_IDLE);
   assign bus.busy  = busy;
   assign bus.done  = done;
   assign bus.rdata = bus.mf_hi ? hi : lo;
   assign bus.stall = busy & (bus.mf_rd | ((bus.op != MDU_NOP) && (bus.op != MDU_RSVD)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         count    <= '0;
         hi       <= '0;
         lo       <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         neg_res  <= 1'b0;
         neg_a    <= 1'b0;
         div_zero <= 1'b0;
         is_div   <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               case (bus.op)
                  MDU_MULT, MDU_MULTU: begin
                     state   <= ST_MUL;
                     count   <= ITER_W'(XLEN-1);
                     acc     <= '0;
                     mcand   <= {{XLEN{1'b0}}, a_mag};
                     mplier  <= b_mag;
                     neg_res <= a_neg ^ b_neg;
                     neg_a   <= a_neg;
                     is_div  <= 1'b0;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     state    <= ST_DIV;
                     count    <= ITER_W'(XLEN-1);
                     div_zero <= (bus.rt_val == '0);
                     // A zero divisor parks the final HI/LO pattern in acc and skips the steps.
                     acc      <= (bus.rt_val == '0) ? {bus.rs_val, {XLEN{1'b1}}}
                                                    : {{XLEN{1'b0}}, a_mag};
                     mplier   <= b_mag;
                     neg_res  <= a_neg ^ b_neg;
                     neg_a    <= a_neg;
                     is_div   <= 1'b1;
                  end
                  MDU_MTHI: hi <= bus.rs_val;
                  MDU_MTLO: lo <= bus.rs_val;
                  default: ;
               endcase
            end
            ST_MUL: begin
               acc    <= mul_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count - 1'b1;
               if (mul_last)
                  state <= ST_FIX;
            end
            ST_DIV: begin
               if (!div_zero)
                  acc <= div_next;
               count <= count - 1'b1;
               if (count == '0)
                  state <= ST_FIX;
            end
            ST_FIX: begin
               if (is_div && div_zero) begin
                  hi <= acc[2*XLEN-1:XLEN];
                  lo <= acc[XLEN-1:0];
               end else if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*XLEN-1:XLEN];
                  lo <= prod_fix[XLEN-1:0];
               end
               done  <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - directed self-checking bench for mdu_hilo
module tb_mdu_hilo;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   mdu_hilo_if #(.XLEN(32)) bus();
   mdu_hilo #(.XLEN(32), .ITER_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.op = op; bus.rs_val = a; bus.rt_val = b;
      @(posedge clk); #1;
      bus.op = MDU_NOP;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.done && n < 100);
   endtask

   task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
      bus.mf_hi = 1'b1; #1; h = bus.rdata;
      bus.mf_hi = 1'b0; #1; l = bus.rdata;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      logic [31:0] h, l;
      issue(op, a, b);
      check({tag, " busy_at_accept"}, 64'(bus.busy), 64'd1);
      wait_done(n);
      check({tag, " latency"}, 64'(n), 64'd33);
      read_hilo(h, l);
      check({tag, " hi"}, 64'(h), 64'(exp_hi));
      check({tag, " lo"}, 64'(l), 64'(exp_lo));
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
      check({tag, " busy_after"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, stall_cnt, stall_bad;
      logic [31:0] h, l;

      bus.op = MDU_NOP; bus.rs_val = '0; bus.rt_val = '0;
      bus.mf_rd = 1'b0; bus.mf_hi = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      read_hilo(h, l);
      check("reset hi", 64'(h), 64'd0);
      check("reset lo", 64'(l), 64'd0);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset stall", 64'(bus.stall), 64'd0);

      run_op("mult_neg",   MDU_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu_max",  MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_neg",    MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_zero",  MDU_DIVU,  32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF);
      run_op("div_zero_s", MDU_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run_op("div_ovf",    MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_op("divu_big",   MDU_DIVU,  32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF);

      // MFLO held while a multiply is in flight
      issue(MDU_MULT, 32'd6, 32'd7);
      bus.mf_rd = 1'b1; bus.mf_hi = 1'b0;
      n = 0; stall_cnt = 0;
      do begin
         if (bus.stall) stall_cnt++;
         @(posedge clk); #1;
         n++;
      end while (!bus.done && n < 100);
      check("mflo latency", 64'(n), 64'd33);
      check("mflo stall_cycles", 64'(stall_cnt), 64'd33);
      check("mflo stall_done", 64'(bus.stall), 64'd0);
      check("mflo rdata", 64'(bus.rdata), 64'h2A);
      bus.mf_rd = 1'b0;

      // DIVU presented during a MULTU is held off until the done cycle ends
      issue(MDU_MULTU, 32'd3, 32'd5);
      bus.op = MDU_DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
      n = 0; stall_bad = 0;
      do begin
         if (!bus.stall) stall_bad++;
         @(posedge clk); #1;
         n++;
      end while (!bus.done && n < 100);
      check("b2b first_latency", 64'(n), 64'd33);
      check("b2b stall_while_busy", 64'(stall_bad), 64'd0);
      check("b2b stall_done", 64'(bus.stall), 64'd0);
      read_hilo(h, l);
      check("b2b mul_lo", 64'(l), 64'd15);
      check("b2b mul_hi", 64'(h), 64'd0);
      @(posedge clk); #1;
      bus.op = MDU_NOP;
      check("b2b accepted_busy", 64'(bus.busy), 64'd1);
      check("b2b accepted_done", 64'(bus.done), 64'd0);
      wait_done(n);
      check("b2b second_latency", 64'(n), 64'd33);
      read_hilo(h, l);
      check("b2b div_lo", 64'(l), 64'd14);
      check("b2b div_hi", 64'(h), 64'd2);

      // MTHI then MFHI on the next cycle
      @(posedge clk); #1;
      issue(MDU_MTHI, 32'h1234_5678, 32'd0);
      bus.mf_rd = 1'b1; bus.mf_hi = 1'b1; #1;
      check("mthi stall", 64'(bus.stall), 64'd0);
      check("mthi busy", 64'(bus.busy), 64'd0);
      check("mthi rdata", 64'(bus.rdata), 64'h1234_5678);
      bus.mf_rd = 1'b0;
      issue(MDU_MTLO, 32'hCAFE_F00D, 32'd0);
      read_hilo(h, l);
      check("mtlo lo", 64'(l), 64'hCAFE_F00D);
      check("mtlo hi_kept", 64'(h), 64'h1234_5678);

      // asynchronous reset in the middle of a divide
      issue(MDU_DIV, 32'd1000, 32'd3);
      repeat (15) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid busy", 64'(bus.busy), 64'd0);
      check("rst_mid done", 64'(bus.done), 64'd0);
      read_hilo(h, l);
      check("rst_mid hi", 64'(h), 64'd0);
      check("rst_mid lo", 64'(l), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_rst", MDU_MULT, 32'd2, 32'd3, 32'd0, 32'd6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
